// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Drives stall/flush/bubble controls from decode, execute and memory status.
module hazard_controller #(
  parameter int AWIDTH            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int WAIT_WIDTH        = 4
) (
  input  logic              hu_clk,
  input  logic              hu_rst,
  input  logic              hu_i_ds_valid,
  input  logic [AWIDTH-1:0] hu_i_ds_rs1,
  input  logic [AWIDTH-1:0] hu_i_ds_rs2,
  input  logic              hu_i_ds_use_rs2,
  input  logic              hu_i_ex_valid,
  input  logic [AWIDTH-1:0] hu_i_ex_rd,
  input  logic              hu_i_ex_is_load,
  input  logic              hu_i_ex_redirect,
  input  logic              hu_i_mem_req,
  input  logic              hu_i_mem_ack,
  output logic              hu_o_fs_stall,
  output logic              hu_o_ds_stall,
  output logic              hu_o_ex_stall,
  output logic              hu_o_ex_bubble,
  output logic              hu_o_fs_flush,
  output logic              hu_o_ds_flush,
  output logic              hu_o_mem_timeout,
  output logic [1:0]        hu_o_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_e;

  localparam logic [1:0] LS_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_WIDTH-1:0] TONE = 1;
  localparam logic [WAIT_WIDTH-1:0] TMAX = '1;
  localparam logic [WAIT_WIDTH-1:0] TPRE = TMAX - TONE;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [WAIT_WIDTH-1:0] tmr_q, tmr_d;

  logic lu, mw, rs_hit;
  logic fs_stall, ds_stall, ex_stall, ex_bubble;
  logic fs_flush, ds_flush, timeout;

  assign rs_hit = (hu_i_ds_rs1 == hu_i_ex_rd) |
                  (hu_i_ds_use_rs2 & (hu_i_ds_rs2 == hu_i_ex_rd));
  assign lu = hu_i_ex_valid & hu_i_ex_is_load &
              (hu_i_ex_rd != '0) & hu_i_ds_valid & rs_hit;
  assign mw = hu_i_mem_req & ~hu_i_mem_ack;

  always_ff @(posedge hu_clk or negedge hu_rst) begin
    if (!hu_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    fs_stall  = 1'b0;
    ds_stall  = 1'b0;
    ex_stall  = 1'b0;
    ex_bubble = 1'b0;
    fs_flush  = 1'b0;
    ds_flush  = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mw) begin
          {fs_stall, ds_stall, ex_stall} = 3'b111;
          state_d = MEM_WAIT;
          tmr_d   = '0;
        end else if (hu_i_ex_redirect) begin
          {fs_flush, ds_flush} = 2'b11;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FL_RELOAD;
          end
        end else if (lu) begin
          {fs_stall, ds_stall, ex_bubble} = 3'b111;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = LS_RELOAD;
          end
        end
      end
      LOAD_STALL: begin
        if (mw) begin
          {fs_stall, ds_stall, ex_stall} = 3'b111;
        end else begin
          {fs_stall, ds_stall, ex_bubble} = 3'b111;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mw) begin
          {fs_stall, ds_stall, ex_stall} = 3'b111;
          timeout = (tmr_q == TPRE);
          if (tmr_q != TMAX) tmr_d = tmr_q + TONE;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        {fs_flush, ds_flush} = 2'b11;
        if (mw) begin
          {fs_stall, ds_stall, ex_stall} = 3'b111;
        end else if (hu_i_ex_redirect) begin
          cnt_d = FL_RELOAD;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Reset forces every control low regardless of inputs
  assign hu_o_fs_stall    = hu_rst & fs_stall;
  assign hu_o_ds_stall    = hu_rst & ds_stall;
  assign hu_o_ex_stall    = hu_rst & ex_stall;
  assign hu_o_ex_bubble   = hu_rst & ex_bubble;
  assign hu_o_fs_flush    = hu_rst & fs_flush;
  assign hu_o_ds_flush    = hu_rst & ds_flush;
  assign hu_o_mem_timeout = hu_rst & timeout;
  assign hu_o_state       = hu_rst ? state_q : RUN;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_hazard_controller;

  logic       clk, rst;
  logic       ds_valid, ds_use_rs2;
  logic [4:0] ds_rs1, ds_rs2, ex_rd;
  logic       ex_valid, ex_is_load, ex_redirect;
  logic       mem_req, mem_ack;
  logic       fs_stall, ds_stall, ex_stall, ex_bubble;
  logic       fs_flush, ds_flush, mem_timeout;
  logic [1:0] state;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1101000;
  localparam logic [6:0] C_MW    = 7'b1110000;
  localparam logic [6:0] C_FL    = 7'b0000110;
  localparam logic [6:0] C_MWFL  = 7'b1110110;
  localparam logic [6:0] C_TO    = 7'b1110001;

  assign ctl = {fs_stall, ds_stall, ex_stall, ex_bubble,
                fs_flush, ds_flush, mem_timeout};

  hazard_controller dut (
    .hu_clk(clk),
    .hu_rst(rst),
    .hu_i_ds_valid(ds_valid),
    .hu_i_ds_rs1(ds_rs1),
    .hu_i_ds_rs2(ds_rs2),
    .hu_i_ds_use_rs2(ds_use_rs2),
    .hu_i_ex_valid(ex_valid),
    .hu_i_ex_rd(ex_rd),
    .hu_i_ex_is_load(ex_is_load),
    .hu_i_ex_redirect(ex_redirect),
    .hu_i_mem_req(mem_req),
    .hu_i_mem_ack(mem_ack),
    .hu_o_fs_stall(fs_stall),
    .hu_o_ds_stall(ds_stall),
    .hu_o_ex_stall(ex_stall),
    .hu_o_ex_bubble(ex_bubble),
    .hu_o_fs_flush(fs_flush),
    .hu_o_ds_flush(ds_flush),
    .hu_o_mem_timeout(mem_timeout),
    .hu_o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    ds_valid = 0; ds_use_rs2 = 0; ds_rs1 = 0; ds_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_redirect = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic use2);
    ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    ds_valid = 1; ds_rs1 = rs1; ds_rs2 = rs2; ds_use_rs2 = use2;
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    mem_req = 1; ex_redirect = 1;
    repeat (2) begin
      nxt(); #1;
      checks++;
      if (ctl !== C_NONE || state !== 2'd0) begin
        errors++;
        $display("FAIL rst_hold ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_NONE);
      end
    end
    nxt(); idle(); rst = 1; #1;
    checks++;
    if (ctl !== C_NONE || state !== 2'd0) begin
      errors++;
      $display("FAIL rst_release ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_NONE);
    end
  endtask

  task automatic test_load_use();
    nxt(); set_lu(5'd2, 5'd2, 5'd0, 1'b0); #1;
    checks++;
    if (ctl !== C_LU || state !== 2'd0) begin
      errors++;
      $display("FAIL lu_stall ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_LU);
    end
    nxt(); ex_valid = 0; ex_is_load = 0; #1;
    checks++;
    if (ctl !== C_NONE || state !== 2'd0) begin
      errors++;
      $display("FAIL lu_release ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_NONE);
    end
    nxt(); set_lu(5'd0, 5'd0, 5'd0, 1'b1); #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL lu_x0 ctl=%b exp %b", ctl, C_NONE);
    end
    nxt(); idle();
  endtask

  task automatic test_rs2();
    nxt(); set_lu(5'd5, 5'd1, 5'd5, 1'b1); #1;
    checks++;
    if (ctl !== C_LU) begin
      errors++;
      $display("FAIL rs2_use ctl=%b exp %b", ctl, C_LU);
    end
    nxt(); set_lu(5'd5, 5'd1, 5'd5, 1'b0); #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL rs2_nouse ctl=%b exp %b", ctl, C_NONE);
    end
    nxt(); idle();
  endtask

  task automatic test_redirect();
    logic [6:0] exp_c [4];
    logic [1:0] exp_s [4];
    logic       rd_in [4];
    for (int pass = 0; pass < 2; pass++) begin
      exp_c = '{C_FL, C_FL, C_FL, C_NONE};
      exp_s = '{2'd0, 2'd3, 2'd3, 2'd0};
      rd_in = '{1'b1, 1'b0, 1'b0, 1'b0};
      if (pass == 1) rd_in[1] = 1'b1;
      else begin
        exp_c[2] = C_NONE; exp_s[2] = 2'd0;
      end
      for (int i = 0; i < 4; i++) begin
        nxt(); ex_redirect = rd_in[i]; #1;
        checks++;
        if (ctl !== exp_c[i] || state !== exp_s[i]) begin
          errors++;
          $display("FAIL redirect p%0d c%0d ctl=%b st=%0d exp ctl=%b st=%0d",
                   pass, i, ctl, state, exp_c[i], exp_s[i]);
        end
      end
      idle();
    end
  endtask

  task automatic test_mem_wait();
    logic [6:0] exp_c [5];
    logic [1:0] exp_s [5];
    exp_c = '{C_MW, C_MW, C_MW, C_NONE, C_NONE};
    exp_s = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    for (int i = 0; i < 5; i++) begin
      nxt();
      mem_req = (i < 4);
      mem_ack = (i == 3);
      #1;
      checks++;
      if (ctl !== exp_c[i] || state !== exp_s[i]) begin
        errors++;
        $display("FAIL memwait c%0d ctl=%b st=%0d exp ctl=%b st=%0d",
                 i, ctl, state, exp_c[i], exp_s[i]);
      end
    end
    idle();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    nxt(); mem_req = 1; #1;
    checks++;
    if (ctl !== C_MW || state !== 2'd0) begin
      errors++;
      $display("FAIL to_enter ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_MW);
    end
    for (int k = 1; k <= 20; k++) begin
      nxt(); #1;
      if (mem_timeout) pulses++;
      checks++;
      if (ctl !== ((k == 15) ? C_TO : C_MW) || state !== 2'd2) begin
        errors++;
        $display("FAIL to_wait k=%0d ctl=%b st=%0d exp ctl=%b st=2",
                 k, ctl, state, (k == 15) ? C_TO : C_MW);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL to_pulses got=%0d exp=1", pulses);
    end
    nxt(); mem_ack = 1; #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL to_ack ctl=%b exp %b", ctl, C_NONE);
    end
    nxt(); idle(); #1;
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL to_exit st=%0d exp 0", state);
    end
  endtask

  task automatic test_simultaneous();
    nxt(); set_lu(5'd3, 5'd3, 5'd0, 1'b0);
    ex_redirect = 1; mem_req = 1; #1;
    checks++;
    if (ctl !== C_MW || state !== 2'd0) begin
      errors++;
      $display("FAIL simul_run ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_MW);
    end
    nxt(); #1;
    checks++;
    if (ctl !== C_MW || state !== 2'd2) begin
      errors++;
      $display("FAIL simul_wait ctl=%b st=%0d exp ctl=%b st=2", ctl, state, C_MW);
    end
    nxt(); idle(); mem_req = 1; mem_ack = 1;
    nxt(); idle(); #1;
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL simul_exit st=%0d exp 0", state);
    end
  endtask

  task automatic test_flush_overlap();
    nxt(); ex_redirect = 1;
    nxt(); ex_redirect = 0; set_lu(5'd4, 5'd4, 5'd0, 1'b0); #1;
    checks++;
    if (ctl !== C_FL || state !== 2'd3) begin
      errors++;
      $display("FAIL flush_lu ctl=%b st=%0d exp ctl=%b st=3", ctl, state, C_FL);
    end
    idle();
    nxt(); ex_redirect = 1;
    nxt(); ex_redirect = 0; mem_req = 1; #1;
    checks++;
    if (ctl !== C_MWFL || state !== 2'd3) begin
      errors++;
      $display("FAIL flush_mw1 ctl=%b st=%0d exp ctl=%b st=3", ctl, state, C_MWFL);
    end
    nxt(); #1;
    checks++;
    if (ctl !== C_MWFL || state !== 2'd3) begin
      errors++;
      $display("FAIL flush_mw2 ctl=%b st=%0d exp ctl=%b st=3", ctl, state, C_MWFL);
    end
    nxt(); mem_ack = 1; #1;
    checks++;
    if (ctl !== C_FL || state !== 2'd3) begin
      errors++;
      $display("FAIL flush_ack ctl=%b st=%0d exp ctl=%b st=3", ctl, state, C_FL);
    end
    nxt(); idle(); #1;
    checks++;
    if (ctl !== C_NONE || state !== 2'd0) begin
      errors++;
      $display("FAIL flush_exit ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_NONE);
    end
  endtask

  task automatic test_reset_mid();
    nxt(); mem_req = 1;
    nxt(); #1;
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL rstmid_pre st=%0d exp 2", state);
    end
    #1 rst = 0;
    #1;
    checks++;
    if (ctl !== C_NONE || state !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_NONE);
    end
    nxt(); idle(); rst = 1; #1;
    checks++;
    if (ctl !== C_NONE || state !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_post ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_NONE);
    end
  endtask

  task automatic test_back_to_back();
    nxt(); set_lu(5'd7, 5'd7, 5'd0, 1'b0); #1;
    checks++;
    if (ctl !== C_LU || state !== 2'd0) begin
      errors++;
      $display("FAIL b2b_lu ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_LU);
    end
    nxt(); ex_redirect = 1; #1;
    checks++;
    if (ctl !== C_FL || state !== 2'd0) begin
      errors++;
      $display("FAIL b2b_redir ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_FL);
    end
    nxt(); idle();
    nxt(); #1;
    checks++;
    if (ctl !== C_NONE || state !== 2'd0) begin
      errors++;
      $display("FAIL b2b_idle ctl=%b st=%0d exp ctl=%b st=0", ctl, state, C_NONE);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rs2();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_simultaneous();
    test_flush_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
